cbd_sampler: RTL and testbench

Centered-binomial noise sampler feeding the linear operation stage of the ML-KEM datapath. It consumes 64-bit PRF output words (SHAKE256 lanes) over a valid/ready stream and produces one polynomial with 256 coefficients in [0, q), where q = 3329. Coefficients are also streamed as they are produced. One instance fills the s, e and r polynomial vectors one polynomial at a time; the parent loads each completed `poly_o` into the consuming vector register.

---
 rtl/cbd_sampler_if.sv | 25 ++
 rtl/cbd_sampler.sv | 126 ++++++++++++
 tb/tb_cbd_sampler.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cbd_sampler_if.sv
// Control and stream bundle of the centered-binomial sampler: start/status, PRF word
// input handshake, coefficient stream and assembled polynomial.
interface cbd_sampler_if;
  typedef logic [255:0][11:0] poly_t;

  logic        start_i;
  logic [63:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [11:0] coef_o;
  logic        coef_valid_o;
  poly_t       poly_o;
  logic        busy_o;
  logic        done_o;

  modport slave (
    input  start_i, in_data_i, in_valid_i,
    output in_ready_o, coef_o, coef_valid_o, poly_o, busy_o, done_o
  );

  modport master (
    output start_i, in_data_i, in_valid_i,
    input  in_ready_o, coef_o, coef_valid_o, poly_o, busy_o, done_o
  );
endinterface

// File: rtl/cbd_sampler.sv
// Centered-binomial sampler: turns an LSB-first stream of 64-bit PRF words into one
// 256-coefficient polynomial mod Q, streaming each coefficient as it is produced.
module cbd_sampler #(
  parameter int ETA = 2,
  parameter int Q   = 3329
) (
  input logic           clk_i,
  input logic           rst_i,
  cbd_sampler_if.slave  bus
);
  localparam int DATA_W = 64;
  localparam int COEF_W = 12;
  localparam int BITS   = 2 * ETA;
  localparam int BUDGET = 256 * BITS / DATA_W;

  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

  state_t                       state_q, state_d;
  logic [127:0]                 buf_q, buf_d;
  logic [7:0]                   fill_q, fill_d;
  logic [4:0]                   words_q, words_d;
  logic [7:0]                   cnt_q, cnt_d;
  logic [COEF_W-1:0]            coef_q, coef_d;
  logic                         coef_vld_q, coef_vld_d;
  logic [255:0][COEF_W-1:0]     poly_q, poly_d;

  logic                         ready;
  logic                         produce;
  logic                         accept;
  logic [127:0]                 shifted;
  logic [7:0]                   fill_c;
  logic [COEF_W-1:0]            coef_val;

  // Maps a centered value in [-ETA, ETA] onto [0, Q).
  function automatic logic [COEF_W-1:0] to_mod(input logic signed [3:0] f);
    if (f < 0) return COEF_W'(Q + int'(f));
    return COEF_W'(int'(f));
  endfunction

  function automatic logic [COEF_W-1:0] cbd_coef(input logic [BITS-1:0] bits);
    logic signed [3:0] f;
    f = '0;
    for (int i = 0; i < ETA; i++) begin
      f = f + $signed({3'b000, bits[i]}) - $signed({3'b000, bits[ETA+i]});
    end
    return to_mod(f);
  endfunction

  assign ready    = (state_q == SAMPLE) && (fill_q <= 8'd64) && (words_q < 5'(BUDGET));
  assign produce  = (state_q == SAMPLE) && (fill_q >= 8'(BITS));
  assign accept   = ready && bus.in_valid_i;
  assign shifted  = produce ? (buf_q >> BITS) : buf_q;
  assign fill_c   = produce ? (fill_q - 8'(BITS)) : fill_q;
  assign coef_val = cbd_coef(buf_q[BITS-1:0]);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    fill_d     = fill_q;
    words_d    = words_q;
    cnt_d      = cnt_q;
    coef_d     = coef_q;
    coef_vld_d = 1'b0;
    poly_d     = poly_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d = SAMPLE;
          buf_d   = '0;
          fill_d  = '0;
          words_d = '0;
          cnt_d   = '0;
        end
      end
      SAMPLE: begin
        // Consume from the pre-append buffer, then append the new word above what remains.
        buf_d  = shifted;
        fill_d = fill_c;
        if (accept) begin
          buf_d   = shifted | ({64'b0, bus.in_data_i} << fill_c);
          fill_d  = fill_c + 8'd64;
          words_d = words_q + 5'd1;
        end
        if (produce) begin
          coef_d     = coef_val;
          coef_vld_d = 1'b1;
          poly_d     = {coef_val, poly_q[255:1]};
          cnt_d      = cnt_q + 8'd1;
          if (cnt_q == 8'd255) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: all state and the registered coefficient stream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      fill_q     <= '0;
      words_q    <= '0;
      cnt_q      <= '0;
      coef_q     <= '0;
      coef_vld_q <= 1'b0;
      poly_q     <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      fill_q     <= fill_d;
      words_q    <= words_d;
      cnt_q      <= cnt_d;
      coef_q     <= coef_d;
      coef_vld_q <= coef_vld_d;
      poly_q     <= poly_d;
    end
  end

  assign bus.in_ready_o   = ready;
  assign bus.coef_o       = coef_q;
  assign bus.coef_valid_o = coef_vld_q;
  assign bus.poly_o       = poly_q;
  assign bus.busy_o       = (state_q != IDLE);
  assign bus.done_o       = (state_q == DONE);
endmodule

// File: tb/tb_cbd_sampler.sv
// Directed bench for cbd_sampler: one ETA=2 and one ETA=3 instance share clock, reset
// and input stream; only the selected instance is started for each polynomial.
module tb_cbd_sampler;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cbd_sampler_if if2();
  cbd_sampler_if if3();

  cbd_sampler #(.ETA(2), .Q(3329)) u2 (.clk_i(clk), .rst_i(rst), .bus(if2.slave));
  cbd_sampler #(.ETA(3), .Q(3329)) u3 (.clk_i(clk), .rst_i(rst), .bus(if3.slave));

  typedef logic [255:0][11:0] poly_t;
  typedef struct {
    int          eta;
    logic [5:0]  grp;
    logic [11:0] exp;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  vec_t        tbl[13];
  logic [63:0] wd[24];
  logic [11:0] expc[256];
  logic [11:0] got[256];
  poly_t       hold2 = '0;
  poly_t       hold3 = '0;

  int r_ncoef, r_words, r_done_e, r_badrdy, r_badvld, r_badhold, r_same;

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic logic rdy_of(input bit s);   return s ? if3.in_ready_o   : if2.in_ready_o;   endfunction
  function automatic logic cv_of(input bit s);    return s ? if3.coef_valid_o : if2.coef_valid_o; endfunction
  function automatic logic [11:0] coef_of(input bit s); return s ? if3.coef_o : if2.coef_o;       endfunction
  function automatic logic done_of(input bit s);  return s ? if3.done_o       : if2.done_o;       endfunction
  function automatic logic busy_of(input bit s);  return s ? if3.busy_o       : if2.busy_o;       endfunction
  function automatic poly_t poly_of(input bit s); return s ? if3.poly_o       : if2.poly_o;       endfunction

  task automatic set_inputs(input bit s, input bit st, input bit v, input logic [63:0] d);
    if2.start_i    = !s && st;
    if3.start_i    = s && st;
    if2.in_valid_i = v;
    if3.in_valid_i = v;
    if2.in_data_i  = d;
    if3.in_data_i  = d;
  endtask

  // Words whose LSB-first stream repeats a 2*eta-bit group.
  task automatic gen_const(input int eta, input logic [5:0] grp);
    for (int w = 0; w < 24; w++)
      for (int k = 0; k < 64; k++)
        wd[w][k] = grp[(64 * w + k) % (2 * eta)];
  endtask

  task automatic gen_rand();
    for (int w = 0; w < 24; w++) wd[w] = {$urandom, $urandom};
  endtask

  function automatic int bitg(input int g);
    return wd[g / 64][g % 64] ? 1 : 0;
  endfunction

  task automatic model(input int eta);
    int a, b;
    for (int i = 0; i < 256; i++) begin
      a = 0; b = 0;
      for (int j = 0; j < eta; j++) begin
        a += bitg(2 * eta * i + j);
        b += bitg(2 * eta * i + eta + j);
      end
      expc[i] = (a >= b) ? 12'(a - b) : 12'(3329 - (b - a));
    end
  endtask

  // disturb: 0 none, 1 extra start at coefficient 100, 2 reset at coefficient 100.
  task automatic run_poly(input bit s, input int eta, input int duty, input int disturb);
    int fill, widx, mcnt, e, budget, nz, nd, nb;
    bit insample, prod_exp, v, hs, rdy, dis_done;
    poly_t hold;
    fill = 0; widx = 0; mcnt = 0; e = 0; budget = 8 * eta;
    insample = 1'b1; prod_exp = 1'b0; dis_done = 1'b0;
    hold = s ? hold3 : hold2;
    r_ncoef = 0; r_words = 0; r_done_e = -1; r_badrdy = 0; r_badvld = 0; r_badhold = 0; r_same = 0;
    @(negedge clk);
    set_inputs(s, 1'b1, 1'b0, wd[0]);
    @(posedge clk);
    while (e < 3000) begin
      @(negedge clk);
      if (cv_of(s) != prod_exp) r_badvld++;
      if (cv_of(s)) begin
        if (r_ncoef < 256) got[r_ncoef] = coef_of(s);
        r_ncoef++;
      end else if (r_ncoef == 0 && poly_of(s) != hold) r_badhold++;
      if (done_of(s)) begin
        r_done_e = e;
        if (cv_of(s) && r_ncoef == 256) r_same = 1;
      end
      if (r_done_e >= 0) break;
      if (disturb == 2 && mcnt == 100) begin
        set_inputs(s, 1'b0, 1'b0, 64'h0);
        rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy_of(s)), 0);
        chk("rst_done", int'(done_of(s)), 0);
        chk("rst_coef_valid", int'(cv_of(s)), 0);
        chk("rst_ready", int'(rdy_of(s)), 0);
        nz = 0;
        for (int i = 0; i < 256; i++) if (poly_of(s)[i] != 12'd0) nz++;
        chk("rst_poly_nonzero", nz, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nd = 0; nb = 0;
        repeat (30) begin
          @(negedge clk);
          nd += int'(done_of(s));
          nb += int'(busy_of(s));
        end
        chk("rst_late_done", nd, 0);
        chk("rst_idle_busy", nb, 0);
        hold2 = '0;
        hold3 = '0;
        return;
      end
      v   = (widx < budget) && (int'($urandom_range(0, 99)) < duty);
      rdy = rdy_of(s);
      if (rdy != (insample && fill <= 64 && widx < budget)) r_badrdy++;
      hs = v && rdy;
      set_inputs(s, disturb == 1 && mcnt == 100 && !dis_done, v, wd[(widx < 24) ? widx : 0]);
      if (disturb == 1 && mcnt == 100) dis_done = 1'b1;
      prod_exp = insample && fill >= 2 * eta;
      fill = fill - (prod_exp ? 2 * eta : 0) + (hs ? 64 : 0);
      if (prod_exp) mcnt++;
      if (mcnt == 256) insample = 1'b0;
      if (hs) widx++;
      @(posedge clk);
      e++;
    end
    set_inputs(s, 1'b0, 1'b0, 64'h0);
    r_words = widx;
  endtask

  task automatic post(input bit s, input int eta, input bit full);
    int nbc, nbp;
    poly_t h;
    chk("done_seen", int'(r_done_e >= 0), 1);
    if (full) chk("done_edge", r_done_e, 257);
    chk("word_count", r_words, 8 * eta);
    chk("coef_count", r_ncoef, 256);
    nbc = 0; nbp = 0;
    for (int i = 0; i < 256; i++) begin
      if (got[i] != expc[i]) nbc++;
      if (poly_of(s)[i] != expc[i]) nbp++;
      h[i] = expc[i];
    end
    chk("coef_stream_bad", nbc, 0);
    chk("poly_bad", nbp, 0);
    chk("ready_bad", r_badrdy, 0);
    chk("coef_valid_bad", r_badvld, 0);
    chk("poly_hold_bad", r_badhold, 0);
    chk("done_with_last_coef", r_same, 1);
    if (s) hold3 = h; else hold2 = h;
  endtask

  task automatic tail(input bit s);
    int nd, nr, nb;
    nd = 0; nr = 0; nb = 0;
    repeat (4) begin
      @(negedge clk);
      nd += int'(done_of(s));
      nr += int'(rdy_of(s));
      nb += int'(busy_of(s));
    end
    chk("tail_done", nd, 0);
    chk("tail_ready", nr, 0);
    chk("tail_busy", nb, 0);
  endtask

  initial begin
    tbl[0]  = '{2, 6'h00, 12'd0};
    tbl[1]  = '{2, 6'h03, 12'd2};
    tbl[2]  = '{2, 6'h0C, 12'd3327};
    tbl[3]  = '{2, 6'h05, 12'd0};
    tbl[4]  = '{2, 6'h01, 12'd1};
    tbl[5]  = '{2, 6'h04, 12'd3328};
    tbl[6]  = '{2, 6'h0E, 12'd3328};
    tbl[7]  = '{3, 6'b000111, 12'd3};
    tbl[8]  = '{3, 6'b111000, 12'd3326};
    tbl[9]  = '{3, 6'b010011, 12'd1};
    tbl[10] = '{3, 6'b111111, 12'd0};
    tbl[11] = '{3, 6'b110001, 12'd3328};
    tbl[12] = '{3, 6'b011000, 12'd3327};

    rst = 1'b1;
    set_inputs(1'b0, 1'b0, 1'b0, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("reset_ready", int'(rdy_of(s[0])), 0);
      chk("reset_coef", int'(coef_of(s[0])), 0);
      chk("reset_coef_valid", int'(cv_of(s[0])), 0);
      chk("reset_poly_zero", int'(poly_of(s[0]) == '0), 1);
      chk("reset_busy", int'(busy_of(s[0])), 0);
      chk("reset_done", int'(done_of(s[0])), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 13; t++) begin
      gen_const(tbl[t].eta, tbl[t].grp);
      for (int i = 0; i < 256; i++) expc[i] = tbl[t].exp;
      run_poly(tbl[t].eta == 3, tbl[t].eta, 100, 0);
      post(tbl[t].eta == 3, tbl[t].eta, 1'b1);
      tail(tbl[t].eta == 3);
    end

    // Backpressure with random data at roughly 30% valid duty.
    gen_rand(); model(2);
    run_poly(1'b0, 2, 30, 0); post(1'b0, 2, 1'b0); tail(1'b0);
    gen_rand(); model(3);
    run_poly(1'b1, 3, 30, 0); post(1'b1, 3, 1'b0); tail(1'b1);

    // A second start mid-polynomial must change nothing, including timing.
    gen_rand(); model(2);
    run_poly(1'b0, 2, 100, 1); post(1'b0, 2, 1'b1); tail(1'b0);

    // Reset mid-polynomial, then a fresh run on the same data.
    gen_rand(); model(3);
    run_poly(1'b1, 3, 100, 2);
    run_poly(1'b1, 3, 100, 0); post(1'b1, 3, 1'b1); tail(1'b1);

    // Back-to-back: second start in the cycle after the done pulse.
    gen_const(2, 6'h03); model(2);
    run_poly(1'b0, 2, 100, 0); post(1'b0, 2, 1'b1);
    gen_const(2, 6'h0C); model(2);
    run_poly(1'b0, 2, 100, 0); post(1'b0, 2, 1'b1); tail(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
